// File: rtl/flash_cmd_decoder_pkg.sv
// rtl/flash_cmd_decoder_pkg.sv - shared states, opcode/command tables and reverse-map helpers
package flash_cmd_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_DECODE,
        ST_ADDR,
        ST_WAIT_CS
    } dec_state_e;

    localparam logic [1:0] FT_WINBOND  = 2'b00;
    localparam logic [1:0] FT_INFINEON = 2'b01;
    localparam logic [1:0] FT_MICRON   = 2'b10;
    localparam logic [1:0] FT_SPANSION = 2'b11;

    // Command indices; 0 is reserved for "no mapping"
    localparam logic [4:0] CMD_NONE                = 5'd0;
    localparam logic [4:0] CMD_READ_INPUT          = 5'd1;
    localparam logic [4:0] CMD_FAST_READ_INPUT     = 5'd2;
    localparam logic [4:0] CMD_DUAL_READ_INPUT     = 5'd3;
    localparam logic [4:0] CMD_DUAL_IO_READ_INPUT  = 5'd4;
    localparam logic [4:0] CMD_QUAD_READ_INPUT     = 5'd5;
    localparam logic [4:0] CMD_QUAD_IO_READ_INPUT  = 5'd6;
    localparam logic [4:0] CMD_WRITE_INPUT         = 5'd7;
    localparam logic [4:0] CMD_SE_INPUT            = 5'd8;
    localparam logic [4:0] CMD_BE_INPUT            = 5'd9;
    localparam logic [4:0] CMD_RST_EN_INPUT        = 5'd10;
    localparam logic [4:0] CMD_RST_INPUT           = 5'd11;
    localparam logic [4:0] CMD_JEDEC_INPUT         = 5'd12;
    localparam logic [4:0] CMD_WREN_INPUT          = 5'd13;
    localparam logic [4:0] CMD_WRDI_INPUT          = 5'd14;
    localparam logic [4:0] CMD_RDSR_INPUT          = 5'd15;
    localparam logic [4:0] CMD_WRSR_INPUT          = 5'd16;
    localparam logic [4:0] CMD_BE_64K_INPUT        = 5'd17;
    localparam logic [4:0] CMD_CE_INPUT            = 5'd18;
    localparam logic [4:0] CMD_QPP_INPUT           = 5'd19;
    localparam logic [4:0] CMD_REMS_INPUT          = 5'd20;
    localparam logic [4:0] CMD_RDCR_INPUT          = 5'd21;
    localparam logic [4:0] CMD_WRCR_INPUT          = 5'd22;

    // Opcodes common to all flash types
    localparam logic [7:0] OP_READ         = 8'h03;
    localparam logic [7:0] OP_FAST_READ    = 8'h0B;
    localparam logic [7:0] OP_DUAL_READ    = 8'h3B;
    localparam logic [7:0] OP_DUAL_IO_READ = 8'hBB;
    localparam logic [7:0] OP_QUAD_READ    = 8'h6B;
    localparam logic [7:0] OP_QUAD_IO_READ = 8'hEB;
    localparam logic [7:0] OP_WRITE        = 8'h02;
    localparam logic [7:0] OP_SE           = 8'hD8;
    localparam logic [7:0] OP_BE           = 8'hC7;
    localparam logic [7:0] OP_RST_EN       = 8'h66;
    localparam logic [7:0] OP_RST          = 8'h99;
    localparam logic [7:0] OP_JEDEC        = 8'h9F;
    localparam logic [7:0] OP_WREN         = 8'h06;
    localparam logic [7:0] OP_WRDI         = 8'h04;
    localparam logic [7:0] OP_RDSR         = 8'h05;
    localparam logic [7:0] OP_WRSR         = 8'h01;
    // Winbond-specific erase opcodes
    localparam logic [7:0] OP_SE_WB        = 8'h20;
    localparam logic [7:0] OP_BE_WB        = 8'h52;
    localparam logic [7:0] OP_BE_64K_WB    = 8'hD8;
    localparam logic [7:0] OP_CE_WB        = 8'hC7;
    // Infineon-only opcodes; WRCR shares 0x01 with WRSR, which wins
    localparam logic [7:0] OP_QPP_IF       = 8'h32;
    localparam logic [7:0] OP_REMS_IF      = 8'h90;
    localparam logic [7:0] OP_RDCR_IF      = 8'h35;
    localparam logic [7:0] OP_WRCR_IF      = 8'h01;

    function automatic logic needs_addr(input logic [4:0] cmd);
        return cmd inside {CMD_READ_INPUT, CMD_FAST_READ_INPUT, CMD_WRITE_INPUT,
                           CMD_SE_INPUT, CMD_BE_INPUT, CMD_BE_64K_INPUT, CMD_QPP_INPUT};
    endfunction

    // Returns {unknown, cmd}; the if-chain order gives first-in-table priority
    function automatic logic [5:0] opcode_to_cmd(input logic [7:0] op, input logic [1:0] ft);
        logic       wb;
        logic       inf;
        logic       hit;
        logic [4:0] c;
        wb  = (ft == FT_WINBOND);
        inf = (ft == FT_INFINEON);
        hit = 1'b1;
        c   = CMD_NONE;
        if (op == OP_READ)                        c = CMD_READ_INPUT;
        else if (op == OP_FAST_READ)              c = CMD_FAST_READ_INPUT;
        else if (op == OP_DUAL_READ)              c = CMD_DUAL_READ_INPUT;
        else if (op == OP_DUAL_IO_READ)           c = CMD_DUAL_IO_READ_INPUT;
        else if (op == OP_QUAD_READ)              c = CMD_QUAD_READ_INPUT;
        else if (op == OP_QUAD_IO_READ)           c = CMD_QUAD_IO_READ_INPUT;
        else if (op == OP_WRITE)                  c = CMD_WRITE_INPUT;
        else if (op == (wb ? OP_SE_WB : OP_SE))   c = CMD_SE_INPUT;
        else if (op == (wb ? OP_BE_WB : OP_BE))   c = CMD_BE_INPUT;
        else if (op == OP_RST_EN)                 c = CMD_RST_EN_INPUT;
        else if (op == OP_RST)                    c = CMD_RST_INPUT;
        else if (op == OP_JEDEC)                  c = CMD_JEDEC_INPUT;
        else if (op == OP_WREN)                   c = CMD_WREN_INPUT;
        else if (op == OP_WRDI)                   c = CMD_WRDI_INPUT;
        else if (op == OP_RDSR)                   c = CMD_RDSR_INPUT;
        else if (op == OP_WRSR)                   c = CMD_WRSR_INPUT;
        else if (wb && op == OP_BE_64K_WB)        c = CMD_BE_64K_INPUT;
        else if (wb && op == OP_CE_WB)            c = CMD_CE_INPUT;
        else if (inf && op == OP_QPP_IF)          c = CMD_QPP_INPUT;
        else if (inf && op == OP_REMS_IF)         c = CMD_REMS_INPUT;
        else if (inf && op == OP_RDCR_IF)         c = CMD_RDCR_INPUT;
        else if (inf && op == OP_WRCR_IF)         c = CMD_WRCR_INPUT;
        else                                      hit = 1'b0;
        return {~hit, c};
    endfunction

endpackage

// File: rtl/flash_cmd_decoder_if.sv
// rtl/flash_cmd_decoder_if.sv - single-line QSPI bus as seen by the decoder
interface flash_cmd_decoder_if;
    logic sck;
    logic cs_n;
    logic io0;

    modport master (output sck, output cs_n, output io0);
    modport slave  (input  sck, input  cs_n, input  io0);
endinterface

// File: rtl/flash_cmd_decoder_sync_edge_det.sv
// rtl/flash_cmd_decoder_sync_edge_det.sv - N-stage synchronizer with rise/fall pulses
module flash_cmd_decoder_sync_edge_det #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/flash_cmd_decoder.sv
// rtl/flash_cmd_decoder.sv - QSPI single-line opcode/address front end for the flash model
module flash_cmd_decoder
    import flash_cmd_decoder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  enable,
    input  logic [1:0]            flash_type_i,
    flash_cmd_decoder_if.slave    bus,
    output logic [4:0]            cmd_o,
    output logic                  cmd_valid_o,
    output logic                  cmd_unknown_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic                  addr_valid_o,
    output logic                  abort_o
);

    localparam logic [4:0] ADDR_LAST = 5'(ADDR_W - 1);

    logic sck_s, sample_en, sck_fall;
    logic cs_s, frame_start, frame_end;
    logic io0_s, io0_rise, io0_fall;
    logic unused_sig;

    flash_cmd_decoder_sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_ni(rst_ni), .async_i(bus.sck),
        .level_o(sck_s), .rise_o(sample_en), .fall_o(sck_fall)
    );

    flash_cmd_decoder_sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_ni(rst_ni), .async_i(bus.cs_n),
        .level_o(cs_s), .rise_o(frame_end), .fall_o(frame_start)
    );

    flash_cmd_decoder_sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_io0 (
        .clk(clk), .rst_ni(rst_ni), .async_i(bus.io0),
        .level_o(io0_s), .rise_o(io0_rise), .fall_o(io0_fall)
    );

    assign unused_sig = ^{sck_s, sck_fall, io0_rise, io0_fall};

    dec_state_e          state_q;
    logic [2:0]          bit_cnt_q;
    logic [4:0]          addr_cnt_q;
    logic [1:0]          ftype_q;
    logic [7:0]          op_sh_q;
    logic [ADDR_W-1:0]   addr_sh_q;
    logic [4:0]          cmd_q;
    logic                cmd_valid_q;
    logic                cmd_unknown_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                addr_valid_q;
    logic                abort_q;
    logic [5:0]          dec_d;
    logic [ADDR_W-1:0]   addr_next_d;

    assign dec_d       = opcode_to_cmd(op_sh_q, ftype_q);
    assign addr_next_d = {addr_sh_q[ADDR_W-2:0], io0_s};

    // Frame FSM: opcode shift, decode, address capture, wait for CS release
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            addr_cnt_q    <= '0;
            ftype_q       <= '0;
            op_sh_q       <= '0;
            addr_sh_q     <= '0;
            cmd_q         <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_unknown_q <= 1'b0;
            addr_q        <= '0;
            addr_valid_q  <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            cmd_valid_q  <= 1'b0;
            addr_valid_q <= 1'b0;
            abort_q      <= 1'b0;
            if (!enable) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (frame_start) begin
                            state_q   <= ST_OPCODE;
                            bit_cnt_q <= '0;
                            op_sh_q   <= '0;
                            ftype_q   <= flash_type_i;
                        end
                    end
                    ST_OPCODE: begin
                        // A final bit coinciding with frame_end still completes
                        if (sample_en) begin
                            op_sh_q   <= {op_sh_q[6:0], io0_s};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_q <= ST_DECODE;
                        end else if (frame_end) begin
                            abort_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_DECODE: begin
                        cmd_unknown_q <= dec_d[5];
                        cmd_q         <= dec_d[4:0];
                        cmd_valid_q   <= 1'b1;
                        addr_cnt_q    <= '0;
                        addr_sh_q     <= '0;
                        // CS may already be released if it rose with the last opcode bit
                        if (cs_s)
                            state_q <= ST_IDLE;
                        else if (!dec_d[5] && needs_addr(dec_d[4:0]))
                            state_q <= ST_ADDR;
                        else
                            state_q <= ST_WAIT_CS;
                    end
                    ST_ADDR: begin
                        if (sample_en) begin
                            addr_sh_q  <= addr_next_d;
                            addr_cnt_q <= addr_cnt_q + 5'd1;
                            if (addr_cnt_q == ADDR_LAST) begin
                                addr_q       <= addr_next_d;
                                addr_valid_q <= 1'b1;
                                state_q      <= ST_WAIT_CS;
                            end
                        end else if (frame_end) begin
                            abort_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_WAIT_CS: begin
                        if (cs_s) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign cmd_o         = cmd_q;
    assign cmd_valid_o   = cmd_valid_q;
    assign cmd_unknown_o = cmd_unknown_q;
    assign addr_o        = addr_q;
    assign addr_valid_o  = addr_valid_q;
    assign abort_o       = abort_q;

endmodule

// File: tb/tb_flash_cmd_decoder.sv
// tb/tb_flash_cmd_decoder.sv - table-driven and scoreboard bench for flash_cmd_decoder
module tb_flash_cmd_decoder;
    import flash_cmd_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        enable = 1'b1;
    logic [1:0]  flash_type_i = 2'b00;
    logic [4:0]  cmd_o;
    logic        cmd_valid_o;
    logic        cmd_unknown_o;
    logic [23:0] addr_o;
    logic        addr_valid_o;
    logic        abort_o;

    int checks = 0;
    int failures = 0;

    flash_cmd_decoder_if bus ();

    flash_cmd_decoder dut (
        .clk(clk), .rst_ni(rst_ni), .enable(enable), .flash_type_i(flash_type_i),
        .bus(bus.slave),
        .cmd_o(cmd_o), .cmd_valid_o(cmd_valid_o), .cmd_unknown_o(cmd_unknown_o),
        .addr_o(addr_o), .addr_valid_o(addr_valid_o), .abort_o(abort_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 cmd, 1 addr, 2 abort
        logic [4:0]  cmd;
        logic        unk;
        logic [23:0] addr;
    } ev_t;

    ev_t exp_q[$];

    typedef struct {
        logic [1:0]  ft;
        logic [7:0]  op;
        logic [23:0] extra;
        bit          send_extra;
        logic [4:0]  exp_cmd;
        logic        exp_unk;
        bit          exp_addr;
    } vec_t;

    vec_t vecs[16];

    task automatic push_cmd(input logic [4:0] c, input logic u);
        ev_t e;
        e.kind = 0; e.cmd = c; e.unk = u; e.addr = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_addr(input logic [23:0] a);
        ev_t e;
        e.kind = 1; e.cmd = '0; e.unk = 1'b0; e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic push_abort();
        ev_t e;
        e.kind = 2; e.cmd = '0; e.unk = 1'b0; e.addr = '0;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [4:0] c, input logic u, input logic [23:0] a);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d cmd=%0d unk=%0b addr=%06h expected none", kind, c, u, a);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                failures++;
                $display("FAIL event_kind got=%0d expected=%0d", kind, e.kind);
            end else if (kind == 0 && (c != e.cmd || u != e.unk)) begin
                failures++;
                $display("FAIL cmd_decode got cmd=%0d unk=%0b expected cmd=%0d unk=%0b", c, u, e.cmd, e.unk);
            end else if (kind == 1 && a != e.addr) begin
                failures++;
                $display("FAIL addr_capture got=%06h expected=%06h", a, e.addr);
            end
        end
    endtask

    // Scoreboard monitor, sampling away from the active edge
    always @(negedge clk) begin
        if (rst_ni) begin
            if (cmd_valid_o)  observe(0, cmd_o, cmd_unknown_o, 24'h0);
            if (addr_valid_o) observe(1, 5'd0, 1'b0, addr_o);
            if (abort_o)      observe(2, 5'd0, 1'b0, 24'h0);
        end
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_events got_pending=%0d expected=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cs_low(input logic [1:0] ft);
        flash_type_i = ft;
        wait_clks(2);
        bus.cs_n = 1'b0;
        wait_clks(4);
    endtask

    task automatic cs_high();
        wait_clks(4);
        bus.cs_n = 1'b1;
        wait_clks(10);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.io0 = bits[n-1-i];
            wait_clks(4);
            bus.sck = 1'b1;
            wait_clks(4);
            bus.sck = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{FT_WINBOND,  8'h9F, 24'h0,      1'b0, CMD_JEDEC_INPUT,        1'b0, 1'b0};
        vecs[1]  = '{FT_MICRON,   8'h03, 24'h123456, 1'b1, CMD_READ_INPUT,         1'b0, 1'b1};
        vecs[2]  = '{FT_WINBOND,  8'h20, 24'hABCDEF, 1'b1, CMD_SE_INPUT,           1'b0, 1'b1};
        vecs[3]  = '{FT_INFINEON, 8'h20, 24'hABCDEF, 1'b1, 5'd0,                   1'b1, 1'b0};
        vecs[4]  = '{FT_INFINEON, 8'h32, 24'h000001, 1'b1, CMD_QPP_INPUT,          1'b0, 1'b1};
        vecs[5]  = '{FT_MICRON,   8'h32, 24'h0,      1'b0, 5'd0,                   1'b1, 1'b0};
        vecs[6]  = '{FT_WINBOND,  8'hC7, 24'h0,      1'b0, CMD_CE_INPUT,           1'b0, 1'b0};
        vecs[7]  = '{FT_INFINEON, 8'hC7, 24'h800000, 1'b1, CMD_BE_INPUT,           1'b0, 1'b1};
        vecs[8]  = '{FT_SPANSION, 8'hD8, 24'hFFFFFF, 1'b1, CMD_SE_INPUT,           1'b0, 1'b1};
        vecs[9]  = '{FT_WINBOND,  8'hD8, 24'h5A5A5A, 1'b1, CMD_BE_64K_INPUT,       1'b0, 1'b1};
        vecs[10] = '{FT_SPANSION, 8'hEB, 24'h112233, 1'b1, CMD_QUAD_IO_READ_INPUT, 1'b0, 1'b0};
        vecs[11] = '{FT_INFINEON, 8'h01, 24'h0,      1'b0, CMD_WRSR_INPUT,         1'b0, 1'b0};
        vecs[12] = '{FT_WINBOND,  8'h35, 24'h0,      1'b0, 5'd0,                   1'b1, 1'b0};
        vecs[13] = '{FT_INFINEON, 8'h35, 24'h0,      1'b0, CMD_RDCR_INPUT,         1'b0, 1'b0};
        vecs[14] = '{FT_MICRON,   8'hFF, 24'h0,      1'b0, 5'd0,                   1'b1, 1'b0};
        vecs[15] = '{FT_INFINEON, 8'h90, 24'h0,      1'b0, CMD_REMS_INPUT,         1'b0, 1'b0};

        bus.cs_n = 1'b1;
        bus.sck  = 1'b0;
        bus.io0  = 1'b0;
        #1 rst_ni = 1'b0;
        wait_clks(3);
        check_eq("reset_cmd",       {27'd0, cmd_o}, 32'd0);
        check_eq("reset_flags",     {28'd0, cmd_valid_o, cmd_unknown_o, addr_valid_o, abort_o}, 32'd0);
        check_eq("reset_addr",      {8'd0, addr_o}, 32'd0);
        rst_ni = 1'b1;
        wait_clks(5);

        for (int i = 0; i < 16; i++) begin
            push_cmd(vecs[i].exp_cmd, vecs[i].exp_unk);
            if (vecs[i].exp_addr) push_addr(vecs[i].extra);
            cs_low(vecs[i].ft);
            send_bits({24'd0, vecs[i].op}, 8);
            if (vecs[i].send_extra) send_bits({8'd0, vecs[i].extra}, 24);
            cs_high();
            check_drained($sformatf("vector_%0d", i));
        end

        // flash type changes mid-frame: latched value applies
        push_cmd(CMD_SE_INPUT, 1'b0);
        push_addr(24'h00F00D);
        cs_low(FT_WINBOND);
        send_bits(32'b00, 2);
        flash_type_i = FT_INFINEON;
        send_bits(32'b100000, 6);
        send_bits(32'h00F00D, 24);
        cs_high();
        check_drained("ftype_latched");

        // CS rises after 5 opcode bits
        push_abort();
        cs_low(FT_WINBOND);
        send_bits(32'b10011, 5);
        cs_high();
        check_drained("abort_mid_opcode");

        push_cmd(CMD_WREN_INPUT, 1'b0);
        cs_low(FT_WINBOND);
        send_bits(32'h06, 8);
        cs_high();
        check_drained("wren_after_abort");

        // abort mid-address
        push_cmd(CMD_READ_INPUT, 1'b0);
        push_abort();
        cs_low(FT_MICRON);
        send_bits(32'h03, 8);
        send_bits(32'hAB, 8);
        cs_high();
        check_drained("abort_mid_addr");

        // fast read with dummy and data clocks
        push_cmd(CMD_FAST_READ_INPUT, 1'b0);
        push_addr(24'h00A5C3);
        cs_low(FT_MICRON);
        send_bits(32'h0B, 8);
        send_bits(32'h00A5C3, 24);
        send_bits(32'h0, 8);
        send_bits(32'hBEEF, 16);
        cs_high();
        check_drained("fast_read_long_frame");

        // CS rises with the final opcode SCK edge: completion wins
        push_cmd(CMD_JEDEC_INPUT, 1'b0);
        cs_low(FT_WINBOND);
        send_bits(32'b1001111, 7);
        bus.io0 = 1'b1;
        wait_clks(4);
        bus.sck  = 1'b1;
        bus.cs_n = 1'b1;
        wait_clks(4);
        bus.sck = 1'b0;
        wait_clks(10);
        check_drained("cs_with_last_bit");

        // enable dropped mid-opcode: no pulses at all
        cs_low(FT_MICRON);
        send_bits(32'b0000, 4);
        enable = 1'b0;
        wait_clks(3);
        enable = 1'b1;
        send_bits(32'b0011, 4);
        send_bits(32'h123456, 24);
        cs_high();
        check_drained("enable_drop");

        // asynchronous reset mid-address
        push_cmd(CMD_WRITE_INPUT, 1'b0);
        cs_low(FT_MICRON);
        send_bits(32'h02, 8);
        send_bits(32'hFFF, 12);
        wait_clks(2);
        check_eq("pre_reset_cmd", {27'd0, cmd_o}, {27'd0, CMD_WRITE_INPUT});
        rst_ni = 1'b0;
        #1;
        check_eq("reset_mid_cmd",   {27'd0, cmd_o}, 32'd0);
        check_eq("reset_mid_addr",  {8'd0, addr_o}, 32'd0);
        check_eq("reset_mid_flags", {28'd0, cmd_valid_o, cmd_unknown_o, addr_valid_o, abort_o}, 32'd0);
        bus.cs_n = 1'b1;
        bus.sck  = 1'b0;
        wait_clks(3);
        rst_ni = 1'b1;
        wait_clks(5);
        check_drained("reset_mid_addr_events");

        push_cmd(CMD_RDSR_INPUT, 1'b0);
        cs_low(FT_WINBOND);
        send_bits(32'h05, 8);
        cs_high();
        check_drained("rdsr_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
